// File: rtl/arm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared encodings for the ARM calculator-core control decoder.
//   - instruction Op field encodings
//   - data-processing cmd field encodings (Funct[4:1])
//   - ALUControl, ImmSrc, ALUSrc and RegSrc codes
//   - packed structs for the main-decode result and the registered outputs
// -----------------------------------------------------------------------------
package arm_ctrl_pkg;

    // Op field, instruction bits 27:26
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field, Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALUControl codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ImmSrc codes: width of the immediate handed to the extender
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // ALUSrc codes: SrcB selection
    localparam logic [1:0] ALUSRC_REG = 2'b00;
    localparam logic [1:0] ALUSRC_IMM = 2'b01;

    // RegSrc codes: [1] read Rd as SrcB, [0] read R15 as SrcA
    localparam logic [1:0] REGSRC_NORM = 2'b00;
    localparam logic [1:0] REGSRC_BR   = 2'b01;
    localparam logic [1:0] REGSRC_STR  = 2'b10;

    // Result of the Op-level decode, before ALU decode adjusts RegW
    typedef struct packed {
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic [1:0] alu_src;
        logic       mem_to_reg;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } main_dec_t;

    // Everything that leaves the block through the output register
    typedef struct packed {
        logic [1:0] flag_w;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic [1:0] alu_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] alu_control;
    } ctrl_out_t;

    localparam main_dec_t MAIN_DEC_NONE = '0;

    // C and V only mean something for the arithmetic ops
    function automatic logic is_arith(input logic [1:0] alu_control);
        return (alu_control == ALU_ADD) || (alu_control == ALU_SUB);
    endfunction

endpackage

// File: rtl/arm_control_decoder_if.sv
// -----------------------------------------------------------------------------
// arm_control_decoder_if
// Groups the instruction fields fed to the control decoder and the control
// signals it returns to the datapath.
//   master : instruction source (drives Op/Funct/Rd, observes controls)
//   slave  : control decoder    (reads Op/Funct/Rd, drives controls)
// Signals:
//   Op[1:0], Funct[5:0], Rd[3:0]          instruction fields
//   FlagW[1:0], PCS, RegW, MemW, MemtoReg,
//   ALUSrc[1:0], ImmSrc[1:0], RegSrc[1:0],
//   ALUControl[1:0]                        registered control outputs
// -----------------------------------------------------------------------------
interface arm_control_decoder_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;

    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       MemtoReg;
    logic [1:0] ALUSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    modport master (
        output Op, Funct, Rd,
        input  FlagW, PCS, RegW, MemW, MemtoReg,
               ALUSrc, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        input  Op, Funct, Rd,
        output FlagW, PCS, RegW, MemW, MemtoReg,
               ALUSrc, ImmSrc, RegSrc, ALUControl
    );

endinterface

// File: rtl/arm_alu_decoder.sv
// -----------------------------------------------------------------------------
// arm_alu_decoder
// Combinational ALU decode for data-processing instructions.
// Ports:
//   alu_op       in   1  main decode says this is a data-processing instr
//   funct[4:0]   in   5  cmd[3:0] in [4:1], S bit in [0]
//   alu_control  out  2  ALU operation select
//   flag_w       out  2  [1] write N,Z ; [0] write C,V
//   no_write     out  1  suppress the register write (CMP, unsupported cmd)
// -----------------------------------------------------------------------------
module arm_alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [4:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;

        if (alu_op) begin
            unique case (cmd)
                CMD_ADD: alu_control = ALU_ADD;
                CMD_SUB: alu_control = ALU_SUB;
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    no_write    = 1'b1;
                end
                // Anything outside the supported subset must never write
                // the register file.
                default: begin
                    alu_control = ALU_ADD;
                    no_write    = 1'b1;
                end
            endcase

            flag_w[1] = s_bit;
            flag_w[0] = s_bit & is_arith(alu_control);
        end
    end

endmodule

// File: rtl/arm_control_decoder.sv
// -----------------------------------------------------------------------------
// arm_control_decoder
// Registered control decoder for the single-cycle ARM calculator core.
// Decodes Op/Funct/Rd into datapath controls; outputs update one clock after
// the instruction fields are presented. No handshake, new decode every cycle.
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous active-low, clears every output
//   ctrl   slave modport of arm_control_decoder_if (fields in, controls out)
// -----------------------------------------------------------------------------
module arm_control_decoder
    import arm_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    arm_control_decoder_if.slave  ctrl
);

    main_dec_t main_dec;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       no_write;
    logic       reg_w_final;
    logic       pcs;
    ctrl_out_t  ctrl_d;
    ctrl_out_t  ctrl_q;

    // Op-level decode
    always_comb begin
        main_dec = MAIN_DEC_NONE;
        unique case (ctrl.Op)
            OP_DP: begin
                main_dec.reg_src = REGSRC_NORM;
                main_dec.imm_src = IMM_8;
                main_dec.alu_src = ctrl.Funct[5] ? ALUSRC_IMM : ALUSRC_REG;
                main_dec.reg_w   = 1'b1;
                main_dec.alu_op  = 1'b1;
            end
            OP_MEM: begin
                main_dec.imm_src = IMM_12;
                main_dec.alu_src = ALUSRC_IMM;
                if (ctrl.Funct[0]) begin
                    main_dec.reg_src    = REGSRC_NORM;
                    main_dec.mem_to_reg = 1'b1;
                    main_dec.reg_w      = 1'b1;
                end else begin
                    // STR reads the Rd field as the store-data source
                    main_dec.reg_src = REGSRC_STR;
                    main_dec.mem_w   = 1'b1;
                end
            end
            OP_BR: begin
                main_dec.reg_src = REGSRC_BR;
                main_dec.imm_src = IMM_24;
                main_dec.alu_src = ALUSRC_IMM;
                main_dec.branch  = 1'b1;
            end
            default: main_dec = MAIN_DEC_NONE;
        endcase
    end

    arm_alu_decoder u_alu_dec (
        .alu_op      (main_dec.alu_op),
        .funct       (ctrl.Funct[4:0]),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .no_write    (no_write)
    );

    assign reg_w_final = main_dec.reg_w & ~no_write;

    // A write that actually lands in R15 redirects the PC just like a branch
    assign pcs = main_dec.branch | ((ctrl.Rd == 4'b1111) & reg_w_final);

    always_comb begin
        ctrl_d             = '0;
        ctrl_d.flag_w      = flag_w;
        ctrl_d.pcs         = pcs;
        ctrl_d.reg_w       = reg_w_final;
        ctrl_d.mem_w       = main_dec.mem_w;
        ctrl_d.mem_to_reg  = main_dec.mem_to_reg;
        ctrl_d.alu_src     = main_dec.alu_src;
        ctrl_d.imm_src     = main_dec.imm_src;
        ctrl_d.reg_src     = main_dec.reg_src;
        ctrl_d.alu_control = alu_control;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ctrl.FlagW      = ctrl_q.flag_w;
    assign ctrl.PCS        = ctrl_q.pcs;
    assign ctrl.RegW       = ctrl_q.reg_w;
    assign ctrl.MemW       = ctrl_q.mem_w;
    assign ctrl.MemtoReg   = ctrl_q.mem_to_reg;
    assign ctrl.ALUSrc     = ctrl_q.alu_src;
    assign ctrl.ImmSrc     = ctrl_q.imm_src;
    assign ctrl.RegSrc     = ctrl_q.reg_src;
    assign ctrl.ALUControl = ctrl_q.alu_control;

endmodule

// File: tb/tb_arm_control_decoder.sv
// -----------------------------------------------------------------------------
// tb_arm_control_decoder
// Directed, table-driven bench for arm_control_decoder plus hand-written
// reset and latency sequences.
// Output word layout used in messages:
//   {FlagW[1:0], PCS, RegW, MemW, MemtoReg, ALUSrc[1:0], ImmSrc[1:0],
//    RegSrc[1:0], ALUControl[1:0]}
// -----------------------------------------------------------------------------
module tb_arm_control_decoder;

    logic clk;
    logic reset;

    arm_control_decoder_if ctrl ();

    arm_control_decoder dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [1:0] flag_w;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic [1:0] alu_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] alu_control;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int checks;
    int errors;

    function automatic logic [15:0] pack_exp(input vec_t v);
        return {v.flag_w, v.pcs, v.reg_w, v.mem_w, v.mem_to_reg,
                v.alu_src, v.imm_src, v.reg_src, v.alu_control};
    endfunction

    function automatic logic [15:0] pack_act();
        return {ctrl.FlagW, ctrl.PCS, ctrl.RegW, ctrl.MemW, ctrl.MemtoReg,
                ctrl.ALUSrc, ctrl.ImmSrc, ctrl.RegSrc, ctrl.ALUControl};
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = pack_act();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // op, funct, rd | flag_w pcs reg_w mem_w m2r alu_src imm_src reg_src alu_ctl
    task automatic fill_vectors();
        vecs[0]  = '{2'b00, 6'b100000, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10}; // AND imm
        vecs[1]  = '{2'b00, 6'b111000, 4'b0010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b11}; // ORR imm
        vecs[2]  = '{2'b00, 6'b101000, 4'b0011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00}; // ADD imm
        vecs[3]  = '{2'b00, 6'b010101, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01}; // CMP
        vecs[4]  = '{2'b00, 6'b000100, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01}; // SUB reg
        vecs[5]  = '{2'b01, 6'b000000, 4'b0101, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b00}; // STR
        vecs[6]  = '{2'b01, 6'b100000, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b00}; // STR I, Rd=15
        vecs[7]  = '{2'b01, 6'b000001, 4'b0110, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00}; // LDR
        vecs[8]  = '{2'b01, 6'b100001, 4'b0111, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00}; // LDR I
        vecs[9]  = '{2'b01, 6'b000001, 4'b1111, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00}; // LDR to PC
        vecs[10] = '{2'b10, 6'b100000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01, 2'b00}; // B
        vecs[11] = '{2'b00, 6'b101000, 4'b1111, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00}; // ADD to PC
        vecs[12] = '{2'b00, 6'b010101, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01}; // CMP Rd=15
        vecs[13] = '{2'b11, 6'b111111, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // Op 11
        vecs[14] = '{2'b11, 6'b000000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // Op 11
        vecs[15] = '{2'b00, 6'b011010, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // unsupported
        vecs[16] = '{2'b00, 6'b001001, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // ADDS reg
        vecs[17] = '{2'b00, 6'b000001, 4'b1001, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10}; // ANDS reg
        vecs[18] = '{2'b00, 6'b111001, 4'b1010, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b11}; // ORRS imm
        vecs[19] = '{2'b00, 6'b011011, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00}; // unsupported S
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd);
        ctrl.Op    = op;
        ctrl.Funct = funct;
        ctrl.Rd    = rd;
    endtask

    // RegW ALUSrc01 ALUControl00, everything else 0
    localparam logic [15:0] EXP_ADD_IMM = 16'b00_0_1_0_0_01_00_00_00;

    initial begin
        checks = 0;
        errors = 0;
        fill_vectors();

        reset = 1'b0;
        drive(2'b00, 6'b101000, 4'b0000);

        @(negedge clk);
        check("reset_state", 16'h0000);
        @(negedge clk);
        check("reset_held", 16'h0000);

        reset = 1'b1;
        @(negedge clk);
        check("first_decode_add_imm", EXP_ADD_IMM);

        // Latency: new input must not appear before the next rising edge
        drive(2'b01, 6'b000000, 4'b0000);
        #2;
        check("latency_hold", EXP_ADD_IMM);
        @(negedge clk);
        check("latency_str", pack_exp(vecs[5]));

        // Back-to-back table, each vector checked one cycle after it is applied
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].funct, vecs[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_exp(vecs[i]));
        end

        // Async reset mid-cycle, no clock edge in between
        drive(2'b00, 6'b101000, 4'b0000);
        @(negedge clk);
        check("pre_async_reset", EXP_ADD_IMM);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_immediate", 16'h0000);
        @(negedge clk);
        check("async_reset_held", 16'h0000);
        reset = 1'b1;
        #1;
        check("release_no_edge", 16'h0000);
        @(negedge clk);
        check("post_reset_add_imm", EXP_ADD_IMM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arm_control_decoder.md
Name: arm_control_decoder

Overview:
- Control decoder for the single-cycle ARM calculator core.
- Decodes instruction fields Op (27:26), Funct (25:20) and Rd (15:12) into datapath control signals.
- Registered: outputs update on the clock edge after inputs are presented; sits between instruction fetch and the conditional-logic/datapath.

Parameters:
- none (all encodings fixed by the ARM subset: data-processing, LDR/STR, B)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all outputs
- Op  in  2  instruction bits 27:26 (00 DP, 01 memory, 10 branch)
- Funct  in  6  instruction bits 25:20 (I, cmd[3:0], S for DP; bit0 = L for memory)
- Rd  in  4  destination register field
- FlagW  out  2  flag-write enables: [1] N,Z ; [0] C,V
- PCS  out  1  PC source: write to R15 or branch
- RegW  out  1  register-file write (unconditional form)
- MemW  out  1  memory write (unconditional form)
- MemtoReg  out  1  result from memory (1) or ALU (0)
- ALUSrc  out  2  00 register operand, 01 extended immediate; 10/11 never driven
- ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24 branch
- RegSrc  out  2  [1] read Rd as SrcB (STR), [0] read R15 as SrcA (B)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Reset (reset=0, async): every output = 0 immediately; held while low.
- Decode is combinational; all outputs registered on rising clk; latency exactly 1 cycle; new decode every cycle, no handshake.
- Main decode by Op:
  - 00, Funct[5]=0 (DP reg): RegSrc00 ImmSrc00 ALUSrc00 MemtoReg0 RegW1 MemW0 Branch0 ALUOp1
  - 00, Funct[5]=1 (DP imm): same but ALUSrc01
  - 01, Funct[0]=0 (STR): RegSrc10 ImmSrc01 ALUSrc01 MemtoReg0 RegW0 MemW1 Branch0 ALUOp0
  - 01, Funct[0]=1 (LDR): RegSrc00 ImmSrc01 ALUSrc01 MemtoReg1 RegW1 MemW0 Branch0 ALUOp0
  - Funct[5] is ignored for Op=01.
  - 10 (B): RegSrc01 ImmSrc10 ALUSrc01 MemtoReg0 RegW0 MemW0 Branch1 ALUOp0
  - 11: all controls 0, Branch0.
- ALU decode when ALUOp=1, by Funct[4:1]:
  - 0100 ADD->00; 0010 SUB->01; 0000 AND->10; 1100 ORR->11
  - 1010 CMP->01, and RegW forced 0
  - any other cmd->00, RegW forced 0 (unsupported op never writes)
- FlagW (ALUOp=1): FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 00 or 01).
- When ALUOp=0: ALUControl=00, FlagW=00.
- PCS = Branch | (Rd==4'b1111 & final RegW).
- Branch is internal only; not a port.
- Rd affects only PCS.

Decomposition:
- Shared package arm_ctrl_pkg:
  - Op encodings OP_DP=00, OP_MEM=01, OP_BR=10
  - ALU codes ALU_ADD/SUB/AND/ORR
  - cmd codes CMD_AND=0000, SUB=0010, ADD=0100, CMP=1010, ORR=1100
  - ImmSrc/ALUSrc constants
- One natural sub-module: arm_alu_decoder (combinational: ALUOp, Funct[4:0] -> ALUControl, FlagW, nowrite).
- Main decode and output register live in the top.

Test Plan:
- Reset: assert reset=0 mid-stream with Op=00/Funct=101000 applied -> all outputs 0 immediately, without waiting for a clock edge; release, next edge -> RegW1 ALUSrc01 ALUControl00.
- DP immediates (each checked one cycle after presentation):
  - Op=00 Funct=100000 (AND imm) -> ALUControl10 ALUSrc01 RegW1 FlagW00 PCS0
  - Funct=111000 (ORR imm) -> ALUControl11 RegW1
  - Funct=101000 (ADD imm) -> ALUControl00
- CMP: Op=00 Funct=010101 -> ALUControl01 ALUSrc00 RegW0 FlagW11 PCS0; Funct=000100 (SUB reg) -> ALUControl01 RegW1 FlagW00.
- Memory:
  - Op=01 Funct=000000 and 100000 (STR) -> MemW1 RegW0 RegSrc10 ImmSrc01 ALUSrc01 ALUControl00
  - Funct=000001 and 100001 (LDR) -> MemtoReg1 RegW1 RegSrc00 MemW0
- Branch/PC:
  - Op=10 Funct=100000 -> PCS1 RegSrc01 ImmSrc10 ALUSrc01 RegW0 MemW0
  - Op=00 Funct=101000 Rd=1111 -> PCS1
  - CMP with Rd=1111 -> PCS0
- Op=11 any Funct, and DP Funct=011010 (unsupported cmd) -> all outputs 0 (RegW0, PCS0).
